// File: rtl/aes_byte_scanner.sv
// Presents a latched 128-bit AES block one byte at a time, MSB byte first, each for DWELL_CYCLES clocks.
// Optional: define AES_SCAN_REPEAT_EN to loop over the block continuously and accept new blocks at any time.
module aes_byte_scanner #(
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [127:0] in_block,
   output logic         in_ready,
   output logic [7:0]   byte_out,
   output logic [3:0]   byte_idx,
   output logic         byte_valid,
   output logic         done
);

   localparam int unsigned CNT_W  = 32;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned BLK_W  = 128;
   localparam int unsigned BYTE_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(15);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BLK_W-1:0]    blk_q, blk_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_d;
   logic [BYTE_W-1:0]   byte_d;
   logic                valid_d;
   logic                done_d;
   logic                ready_d;
   logic                accept;
   logic                dwell_end;
   logic [6:0]          shamt;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         blk_q      <= '0;
         cnt_q      <= '0;
         byte_idx   <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         done       <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         cnt_q      <= cnt_d;
         byte_idx   <= idx_d;
         byte_out   <= byte_d;
         byte_valid <= valid_d;
         done       <= done_d;
         in_ready   <= ready_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      cnt_d     = cnt_q;
      idx_d     = byte_idx;
      done_d    = 1'b0;
      byte_d    = '0;
      valid_d   = 1'b0;
      ready_d   = 1'b1;
      shamt     = '0;
      accept    = in_valid && in_ready;
      dwell_end = (cnt_q == CNT_LAST);

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = SHOW;
               blk_d   = in_block;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         SHOW: begin
            if (dwell_end) begin
               cnt_d = '0;
               if (byte_idx == IDX_LAST) begin
                  done_d = 1'b1;
`ifdef AES_SCAN_REPEAT_EN
                  idx_d  = '0;
`else
                  state_d = DONE;
`endif
               end else begin
                  idx_d = byte_idx + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // A new block overrides a wrap; the wrap's done pulse is kept
            if (accept) begin
               blk_d = in_block;
               cnt_d = '0;
               idx_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            blk_d   = '0;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Byte 0 lives in the top bits of the block
      shamt = {IDX_W'(IDX_LAST - idx_d), 3'b000};
      if (state_d != IDLE) begin
         byte_d  = BYTE_W'(blk_d >> shamt);
         valid_d = 1'b1;
      end

`ifdef AES_SCAN_REPEAT_EN
      ready_d = 1'b1;
`else
      ready_d = (state_d != SHOW);
`endif
   end

endmodule

// File: tb/tb_aes_byte_scanner.sv
// Randomized self-checking bench for aes_byte_scanner (DWELL_CYCLES=4) against a cycle-count reference model.
module tb_aes_byte_scanner;

   localparam int unsigned D = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [127:0] in_block;
   logic         in_ready;
   logic [7:0]   byte_out;
   logic [3:0]   byte_idx;
   logic         byte_valid;
   logic         done;

   int n_total;
   int n_bad;

   // Reference model: block latched on last accept, k = cycles since that accept (1 = first cycle)
   logic         m_active;
   logic [127:0] m_blk;
   int           m_k;

   logic         e_ready, e_valid, e_done;
   logic [7:0]   e_byte;
   logic [3:0]   e_idx;

   aes_byte_scanner #(.DWELL_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_block   (in_block),
      .in_ready   (in_ready),
      .byte_out   (byte_out),
      .byte_idx   (byte_idx),
      .byte_valid (byte_valid),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
      logic [127:0] s;
      s = b >> (8 * (15 - i));
      return s[7:0];
   endfunction

   task automatic model_expect();
      int i;
      if (!m_active) begin
         e_ready = 1'b1; e_valid = 1'b0; e_done = 1'b0; e_byte = 8'h00; e_idx = 4'd0;
      end else begin
         e_valid = 1'b1;
`ifdef AES_SCAN_REPEAT_EN
         i       = ((m_k - 1) / D) % 16;
         e_done  = (m_k > 1) && (((m_k - 1) % (16 * D)) == 0);
         e_ready = 1'b1;
`else
         if (m_k <= 16 * D) begin
            i       = (m_k - 1) / D;
            e_ready = 1'b0;
         end else begin
            i       = 15;
            e_ready = 1'b1;
         end
         e_done = (m_k == 16 * D + 1);
`endif
         e_idx  = 4'(i);
         e_byte = byte_of(m_blk, i);
      end
   endtask

   // Apply current inputs across one rising edge, advance the model, then check all outputs
   task automatic step();
      logic acc;
      model_expect();
      acc = in_valid && e_ready;
      @(posedge clk);
      if (acc) begin
         m_active = 1'b1; m_blk = in_block; m_k = 1;
      end else if (m_active) begin
         m_k++;
      end
      #1;
      model_expect();
      check("in_ready",   32'(in_ready),   32'(e_ready));
      check("byte_valid", 32'(byte_valid), 32'(e_valid));
      check("done",       32'(done),       32'(e_done));
      check("byte_idx",   32'(byte_idx),   32'(e_idx));
      check("byte_out",   32'(byte_out),   32'(e_byte));
   endtask

   function automatic logic [127:0] rnd_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      n_total  = 0;
      n_bad    = 0;
      m_active = 1'b0;
      m_blk    = '0;
      m_k      = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_block = '0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_byte_out", 32'(byte_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      for (int c = 0; c < 10; c++) step();

      // Known vector, full scan into DONE
      in_valid = 1'b1;
      in_block = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      step();
      check("vec_first_byte", 32'(byte_out), 32'h69);
      in_valid = 1'b0;
      in_block = rnd_block();
      for (int c = 0; c < 4; c++) step();
      check("vec_second_byte", 32'(byte_out), 32'hc4);
      for (int c = 0; c < 66; c++) step();

      // in_valid held with a new block throughout a scan
      in_valid = 1'b1;
      in_block = rnd_block();
      step();
      in_block = rnd_block();
      for (int c = 0; c < 70; c++) step();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) step();

      // Random traffic with in_block churning every cycle
      for (int c = 0; c < 500; c++) begin
         in_valid = ($urandom_range(0, 7) == 0);
         in_block = rnd_block();
         step();
      end

      // Asynchronous reset mid-scan at byte 7
      in_valid = 1'b0;
      for (int c = 0; c < 80; c++) step();
      in_valid = 1'b1;
      in_block = rnd_block();
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 100 && !(m_active && ((m_k - 1) / D) == 7); c++) step();
      check("reached_idx7", 32'(byte_idx), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      m_active = 1'b0;
      check("arst_byte_valid", 32'(byte_valid), 32'd0);
      check("arst_byte_idx",   32'(byte_idx),   32'd0);
      check("arst_byte_out",   32'(byte_out),   32'd0);
      check("arst_in_ready",   32'(in_ready),   32'd1);
      check("arst_done",       32'(done),       32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 70; c++) step();
      in_valid = 1'b1;
      in_block = rnd_block();
      step();
      check("restart_idx", 32'(byte_idx), 32'd0);
      in_valid = 1'b0;

      // More random traffic
      for (int c = 0; c < 300; c++) begin
         in_valid = ($urandom_range(0, 15) == 0);
         in_block = rnd_block();
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
